// File: rtl/attention_av_stream_mp.sv
`default_nettype none
// ============================================================================
// Module   : attention_av_stream_mp
// Brief    : Streaming A*V multiplier. Columns arrive with a per-beat precision
//            tag, are MAC'd tile by tile, then streamed out as saturated rows.
// Revision : 1.0 - initial release
// ============================================================================
module attention_av_stream_mp #(
  parameter int A_ROWS    = 8,
  parameter int V_COLS    = 32,
  parameter int TILE_SIZE = 8,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_prec,
  input  logic                         in_last,
  input  logic [A_ROWS*DATA_W-1:0]     in_a,
  input  logic [V_COLS*DATA_W-1:0]     in_v,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(A_ROWS)-1:0]    out_row_idx,
  output logic [V_COLS*DATA_W-1:0]     out_row,
  output logic                         out_last,
  output logic                         sat_flag
);

  localparam int c_NUM_TILES = V_COLS / TILE_SIZE;
  localparam int c_TILE_W    = (c_NUM_TILES > 1) ? $clog2(c_NUM_TILES) : 1;
  localparam int c_ROW_W     = $clog2(A_ROWS);
  localparam int c_PROD_W    = 2 * DATA_W;

  localparam logic [1:0] c_COL_WAIT = 2'd0;
  localparam logic [1:0] c_MUL      = 2'd1;
  localparam logic [1:0] c_ACC      = 2'd2;
  localparam logic [1:0] c_OUT      = 2'd3;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_nxt;
  logic [A_ROWS*DATA_W-1:0]    r_a;
  logic [V_COLS*DATA_W-1:0]    r_v;
  logic [1:0]                  r_prec;
  logic                        r_last;
  logic [c_TILE_W-1:0]         r_tile;
  logic [1:0]                  r_lat;
  logic [c_ROW_W-1:0]          r_row_idx;

  logic                        w_in_hs;
  logic                        w_out_hs;
  logic                        w_row_done;
  logic                        w_last_tile;
  logic [1:0]                  w_lat_max;
  logic [DATA_W-1:0]           w_mask;

  logic [A_ROWS*TILE_SIZE*c_PROD_W-1:0] w_prod_flat;
  logic [A_ROWS*V_COLS*DATA_W-1:0]      w_conv_flat;
  logic [A_ROWS*V_COLS-1:0]             w_sat_el;

  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_row_done  = w_out_hs && (r_row_idx == c_ROW_W'(A_ROWS - 1));
  assign w_last_tile = (r_tile == c_TILE_W'(c_NUM_TILES - 1));

  // Latency is one less than the MUL dwell (counter starts at zero); the mask
  // keeps only the MSBs so a single 16x16 multiplier yields a Q2.30 product.
  always_comb begin
    w_lat_max = 2'd3;
    w_mask    = 16'hFFFF;
    case (r_prec)
      2'b00: begin
        w_lat_max = 2'd0;
        w_mask    = 16'hF000;
      end
      2'b01: begin
        w_lat_max = 2'd1;
        w_mask    = 16'hFF00;
      end
      default: begin
        w_lat_max = 2'd3;
        w_mask    = 16'hFFFF;
      end
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_COL_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_COL_WAIT: if (w_in_hs) w_state_nxt = c_MUL;
      c_MUL:      if (r_lat == w_lat_max) w_state_nxt = c_ACC;
      c_ACC: begin
        if (!w_last_tile)  w_state_nxt = c_MUL;
        else if (r_last)   w_state_nxt = c_OUT;
        else               w_state_nxt = c_COL_WAIT;
      end
      c_OUT:      if (w_row_done) w_state_nxt = c_COL_WAIT;
      default:    w_state_nxt = c_COL_WAIT;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == c_COL_WAIT);
    out_valid   = (r_state == c_OUT);
    out_last    = (r_state == c_OUT) && (r_row_idx == c_ROW_W'(A_ROWS - 1));
    out_row_idx = r_row_idx;
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_v       <= '0;
      r_prec    <= 2'b00;
      r_last    <= 1'b0;
      r_tile    <= '0;
      r_lat     <= 2'd0;
      r_row_idx <= '0;
    end else begin
      if (w_in_hs) begin
        r_a    <= in_a;
        r_v    <= in_v;
        r_prec <= in_prec;
        r_last <= in_last;
        r_tile <= '0;
      end else if ((r_state == c_ACC) && !w_last_tile) begin
        r_tile <= r_tile + c_TILE_W'(1);
      end

      if ((r_state == c_MUL) && (r_lat != w_lat_max)) begin
        r_lat <= r_lat + 2'd1;
      end else begin
        r_lat <= 2'd0;
      end

      if (w_out_hs) begin
        r_row_idx <= w_row_done ? '0 : (r_row_idx + c_ROW_W'(1));
      end
    end
  end

  // ---------------------------------------------------------------- products
  generate
    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_prod_row
      for (genvar gt = 0; gt < TILE_SIZE; gt++) begin : g_prod_col
        logic signed [DATA_W-1:0]   w_aq;
        logic signed [DATA_W-1:0]   w_vq;
        logic signed [c_PROD_W-1:0] w_p;
        assign w_aq = r_a[gi*DATA_W +: DATA_W] & w_mask;
        assign w_vq = r_v[(int'(r_tile)*TILE_SIZE + gt)*DATA_W +: DATA_W] & w_mask;
        assign w_p  = w_aq * w_vq;
        assign w_prod_flat[(gi*TILE_SIZE + gt)*c_PROD_W +: c_PROD_W] = w_p;
      end
    end
  endgenerate

  // ---------------------------------------------------------------- accumulators
  generate
    for (genvar gi = 0; gi < A_ROWS; gi++) begin : g_acc_row
      for (genvar gj = 0; gj < V_COLS; gj++) begin : g_acc_col
        localparam int c_TILE = gj / TILE_SIZE;
        localparam int c_POS  = gi*TILE_SIZE + (gj % TILE_SIZE);

        logic signed [ACC_W-1:0]    r_acc;
        logic        [c_PROD_W-1:0] w_p;
        logic                       w_ovf;

        assign w_p = w_prod_flat[c_POS*c_PROD_W +: c_PROD_W];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_acc <= '0;
          end else if (w_row_done) begin
            r_acc <= '0;
          end else if ((r_state == c_ACC) && (r_tile == c_TILE_W'(c_TILE))) begin
            r_acc <= r_acc + {{(ACC_W-c_PROD_W){w_p[c_PROD_W-1]}}, w_p};
          end
        end

        // acc>>>15 fits 16 signed bits only when acc[ACC_W-1:30] is all-equal.
        assign w_ovf = !((&r_acc[ACC_W-1:30]) || (~|r_acc[ACC_W-1:30]));
        assign w_sat_el[gi*V_COLS + gj] = w_ovf;
        assign w_conv_flat[(gi*V_COLS + gj)*DATA_W +: DATA_W] =
            w_ovf ? (r_acc[ACC_W-1] ? 16'h8000 : 16'h7FFF) : r_acc[30:15];
      end
    end
  endgenerate

  // Accumulators are frozen in OUT, so the whole-matrix OR holds steady there.
  always_comb begin
    out_row  = '0;
    sat_flag = (r_state == c_OUT) && (|w_sat_el);
    if (r_state == c_OUT) begin
      for (int j = 0; j < V_COLS; j++) begin
        out_row[j*DATA_W +: DATA_W] =
            w_conv_flat[(int'(r_row_idx)*V_COLS + j)*DATA_W +: DATA_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attention_av_stream_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_attention_av_stream_mp
// Brief    : Directed self-checking bench for attention_av_stream_mp.
// Revision : 1.0 - initial release
// ============================================================================
module tb_attention_av_stream_mp;

  localparam int A_ROWS = 8;
  localparam int V_COLS = 32;
  localparam int DW     = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [1:0]             in_prec = 2'b00;
  logic                   in_last = 1'b0;
  logic [A_ROWS*DW-1:0]   in_a = '0;
  logic [V_COLS*DW-1:0]   in_v = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [2:0]             out_row_idx;
  logic [V_COLS*DW-1:0]   out_row;
  logic                   out_last;
  logic                   sat_flag;

  int checks   = 0;
  int failures = 0;

  attention_av_stream_mp #(
    .A_ROWS(A_ROWS), .V_COLS(V_COLS), .TILE_SIZE(8), .DATA_W(DW), .ACC_W(40)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prec(in_prec),
    .in_last(in_last), .in_a(in_a), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
    .out_row(out_row), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  function automatic logic [A_ROWS*DW-1:0] fill_a(input logic [15:0] x);
    logic [A_ROWS*DW-1:0] r;
    for (int i = 0; i < A_ROWS; i++) r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic logic [V_COLS*DW-1:0] fill_v(input logic [15:0] x);
    logic [V_COLS*DW-1:0] r;
    for (int j = 0; j < V_COLS; j++) r[j*DW +: DW] = x;
    return r;
  endfunction

  // Drive one column beat; low = cycles in_ready stays low (or until OUT).
  task automatic send_col(input logic [1:0] p, input logic l,
                          input logic [A_ROWS*DW-1:0] a,
                          input logic [V_COLS*DW-1:0] v, output int low);
    int n;
    in_valid = 1'b1; in_prec = p; in_last = l; in_a = a; in_v = v;
    n = 0;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    low = 0;
    while (!in_ready && !out_valid && low < 1000) begin
      low++; @(posedge clk); #1;
    end
  endtask

  task automatic recv(output logic [V_COLS*DW-1:0] row, output logic [2:0] idx,
                      output logic lst, output logic sat, output bit to);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 1000) begin @(posedge clk); #1; n++; end
    to = !out_valid;
    row = out_row; idx = out_row_idx; lst = out_last; sat = sat_flag;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_row_idx !== 3'd0) begin failures++; $display("FAIL rst_row_idx got=%0d exp=0", out_row_idx); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL rst_sat_flag got=%b exp=0", sat_flag); end
    checks++; if (out_row !== '0) begin failures++; $display("FAIL rst_out_row got=%h exp=0", out_row); end
  endtask

  task automatic test_fp16_single;
    int low; logic [V_COLS*DW-1:0] row; logic [2:0] idx; logic lst, sat; bit to;
    send_col(2'b10, 1'b1, fill_a(16'h4000), fill_v(16'h4000), low);
    checks++; if (low != 20) begin failures++; $display("FAIL fp16_latency got=%0d exp=20", low); end
    for (int r = 0; r < A_ROWS; r++) begin
      recv(row, idx, lst, sat, to);
      checks++; if (to) begin failures++; $display("FAIL fp16_timeout row=%0d got=timeout exp=valid", r); end
      checks++; if (row !== fill_v(16'h2000)) begin failures++; $display("FAIL fp16_row%0d got=%h exp=2000s", r, row); end
      checks++; if (idx !== 3'(r)) begin failures++; $display("FAIL fp16_idx got=%0d exp=%0d", idx, r); end
      checks++; if (lst !== (r == A_ROWS-1)) begin failures++; $display("FAIL fp16_last row=%0d got=%b", r, lst); end
      checks++; if (sat !== 1'b0) begin failures++; $display("FAIL fp16_sat row=%0d got=%b exp=0", r, sat); end
    end
  endtask

  task automatic test_precisions;
    logic [1:0]  p_tab [3] = '{2'b00, 2'b01, 2'b10};
    logic [15:0] e_tab [3] = '{16'h3800, 16'h3F80, 16'h3FFF};
    int          l_tab [3] = '{8, 12, 20};
    int low; logic [V_COLS*DW-1:0] row; logic [2:0] idx; logic lst, sat; bit to;
    for (int k = 0; k < 3; k++) begin
      send_col(p_tab[k], 1'b1, fill_a(16'h4000), fill_v(16'h7FFF), low);
      checks++; if (low != l_tab[k]) begin failures++; $display("FAIL prec%0d_latency got=%0d exp=%0d", k, low, l_tab[k]); end
      for (int r = 0; r < A_ROWS; r++) begin
        recv(row, idx, lst, sat, to);
        checks++; if (to || row !== fill_v(e_tab[k])) begin failures++; $display("FAIL prec%0d_row%0d got=%h exp=%h", k, r, row[15:0], e_tab[k]); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL prec%0d_sat got=%b exp=0", k, sat); end
      end
    end
  endtask

  task automatic test_saturation;
    int          n_tab [2] = '{3, 2};
    logic [15:0] a_tab [2] = '{16'h7FFF, 16'h8000};
    logic [15:0] e_tab [2] = '{16'h7FFF, 16'h8000};
    int low; logic [V_COLS*DW-1:0] row; logic [2:0] idx; logic lst, sat; bit to;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < n_tab[k]; c++)
        send_col(2'b10, (c == n_tab[k]-1), fill_a(a_tab[k]), fill_v(16'h7FFF), low);
      for (int r = 0; r < A_ROWS; r++) begin
        recv(row, idx, lst, sat, to);
        checks++; if (to || row !== fill_v(e_tab[k])) begin failures++; $display("FAIL sat%0d_row%0d got=%h exp=%h", k, r, row[15:0], e_tab[k]); end
        checks++; if (sat !== 1'b1) begin failures++; $display("FAIL sat%0d_flag got=%b exp=1", k, sat); end
      end
    end
  endtask

  // 0x2000*0x4000 + 0x1200*0x2000 + 0x0101*0x0100 - 0x0100 = 0x0A410000 -> 0x1482
  task automatic test_mixed;
    logic [1:0]  p_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [15:0] a_tab [4] = '{16'h2FFF, 16'h12FF, 16'h0101, 16'hFFFF};
    logic [15:0] v_tab [4] = '{16'h4000, 16'h2000, 16'h0100, 16'h0100};
    int          l_tab [4] = '{8, 12, 20, 20};
    int low; logic [V_COLS*DW-1:0] row; logic [2:0] idx; logic lst, sat; bit to;
    for (int c = 0; c < 4; c++) begin
      send_col(p_tab[c], (c == 3), fill_a(a_tab[c]), fill_v(v_tab[c]), low);
      checks++; if (low != l_tab[c]) begin failures++; $display("FAIL mixed_latency col=%0d got=%0d exp=%0d", c, low, l_tab[c]); end
    end
    for (int r = 0; r < A_ROWS; r++) begin
      recv(row, idx, lst, sat, to);
      checks++; if (to || row !== fill_v(16'h1482)) begin failures++; $display("FAIL mixed_row%0d got=%h exp=1482", r, row[15:0]); end
    end
  endtask

  // a[i]=(i+1)*0x0800, v[j]=(j+1)*0x0100 -> element (i,j) = (i+1)*(j+1)*16
  task automatic test_backpressure;
    logic [A_ROWS*DW-1:0] a; logic [V_COLS*DW-1:0] v, exp_row, hold;
    int low; logic [V_COLS*DW-1:0] row; logic [2:0] idx; logic lst, sat; bit to;
    for (int i = 0; i < A_ROWS; i++) a[i*DW +: DW] = 16'((i+1) * 16'h0800);
    for (int j = 0; j < V_COLS; j++) v[j*DW +: DW] = 16'((j+1) * 16'h0100);
    send_col(2'b10, 1'b1, a, v, low);
    for (int r = 0; r < A_ROWS; r++) begin
      for (int j = 0; j < V_COLS; j++) exp_row[j*DW +: DW] = 16'((r+1)*(j+1)*16);
      if (r == 3) begin
        hold = out_row;
        checks++; if (hold !== exp_row) begin failures++; $display("FAIL bp_row3_pre got=%h exp=%h", hold[63:0], exp_row[63:0]); end
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          checks++; if (out_valid !== 1'b1 || out_row_idx !== 3'd3) begin failures++; $display("FAIL bp_hold got=v%b/i%0d exp=v1/i3", out_valid, out_row_idx); end
          checks++; if (out_row !== hold) begin failures++; $display("FAIL bp_stable got=%h exp=%h", out_row[63:0], hold[63:0]); end
          checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
        end
      end
      recv(row, idx, lst, sat, to);
      checks++; if (to || row !== exp_row || idx !== 3'(r)) begin failures++; $display("FAIL bp_row%0d got=%h idx=%0d exp=%h", r, row[63:0], idx, exp_row[63:0]); end
    end
    send_col(2'b10, 1'b1, fill_a(16'h4000), fill_v(16'h4000), low);
    for (int r = 0; r < A_ROWS; r++) begin
      recv(row, idx, lst, sat, to);
      checks++; if (to || row !== fill_v(16'h2000)) begin failures++; $display("FAIL bp_next_row%0d got=%h exp=2000", r, row[15:0]); end
    end
  endtask

  task automatic test_reset_mid;
    int low, n; logic [V_COLS*DW-1:0] row; logic [2:0] idx; logic lst, sat; bit to;
    send_col(2'b10, 1'b0, fill_a(16'h7FFF), fill_v(16'h7FFF), low);
    checks++; if (low != 20) begin failures++; $display("FAIL rmid_col1 got=%0d exp=20", low); end
    in_valid = 1'b1; in_prec = 2'b10; in_last = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    send_col(2'b10, 1'b1, fill_a(16'h4000), fill_v(16'h4000), low);
    for (int r = 0; r < A_ROWS; r++) begin
      recv(row, idx, lst, sat, to);
      checks++; if (to || row !== fill_v(16'h2000)) begin failures++; $display("FAIL rmid_row%0d got=%h exp=2000", r, row[15:0]); end
      checks++; if (sat !== 1'b0) begin failures++; $display("FAIL rmid_sat got=%b exp=0", sat); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fp16_single();
    test_precisions();
    test_saturation();
    test_mixed();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
